// File: rtl/dmi_pkg.sv
// dmi_pkg
//   Shared definitions for the DMI arbiter slice: default DMI widths, the
//   arbiter state encoding and the requester id constants used by both the
//   arbiter and its round-robin grant helper.
//   No ports (package).
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dmi_state_t;

  // Requester ids, also used as the priority / owner encoding
  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // The requester that gets preference after `id` has been served
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/dmi_arbiter_rr_arb2.sv
// rr_arb2
//   Purely combinational two-way round-robin grant. The priority state lives
//   in the caller; this block only resolves one cycle's requests.
//   Ports:
//     req0, req1 : request from requester 0 / 1
//     prio       : requester preferred when both request (REQ_M0 / REQ_M1)
//     grant      : one-hot grant, bit 0 = requester 0, bit 1 = requester 1
//     winner     : id of the granted requester (meaningful only if grant != 0)
module rr_arb2
  import dmi_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       winner
);

  // Requester 0 wins when it is alone or when it holds priority; otherwise
  // requester 1 wins whenever it requests.
  always_comb begin
    grant  = 2'b00;
    winner = REQ_M0;
    if (req0 && (!req1 || (prio == REQ_M0))) begin
      grant  = 2'b01;
      winner = REQ_M0;
    end else if (req1) begin
      grant  = 2'b10;
      winner = REQ_M1;
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter
//   Shares the single DMI port of the debug module between the JTAG DTM (m0)
//   and a secondary host bridge (m1). One command is accepted at a time via
//   valid/ready, issued as a single-cycle dmi_valid strobe, and after the
//   fixed read latency a one-cycle response pulse returns to the issuer.
//   Ports:
//     clk, resetn            : clock, synchronous active-low reset
//     mX_req_valid/ready     : command handshake for requester X (0/1)
//     mX_req_wr/addr/wdata   : command type, register address, write data
//     mX_rsp_valid/rdata     : one-cycle response pulse, read data (0 on write)
//     dmi_valid              : single-cycle access strobe to the debug module
//     dmi_wr/addr/wdata      : access type, address, write data (held when idle)
//     dmi_rdata              : registered read data from the debug module
//   RD_LATENCY (legal 1..15) is the cycle count from the dmi_valid cycle to
//   the cycle in which dmi_rdata is valid.
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter int ADDR_W     = DMI_ADDR_W,
  parameter int DATA_W     = DMI_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_wr,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_wr,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,

  output logic              dmi_valid,
  output logic              dmi_wr,
  output logic [ADDR_W-1:0] dmi_addr,
  output logic [DATA_W-1:0] dmi_wdata,
  input  logic [DATA_W-1:0] dmi_rdata
);

  // WAIT counts down from RD_LATENCY-1 so that the zero cycle is exactly the
  // cycle in which the debug module presents the read data.
  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

  dmi_state_t        state;
  dmi_state_t        state_nxt;
  logic              prio;
  logic              owner;
  logic [3:0]        wait_cnt;

  logic [1:0]        grant;
  logic              winner;
  logic              accept;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              capture_rsp;
  logic [DATA_W-1:0] rsp_data_nxt;

  rr_arb2 u_rr_arb2 (
    .req0   (m0_req_valid),
    .req1   (m1_req_valid),
    .prio   (prio),
    .grant  (grant),
    .winner (winner)
  );

  // Ready is offered only in IDLE, and is held off while reset is asserted
  // so a requester never sees a handshake on an edge that resets the arbiter.
  assign m0_req_ready = resetn && (state == ST_IDLE) && grant[0];
  assign m1_req_ready = resetn && (state == ST_IDLE) && grant[1];
  assign accept       = m0_req_ready || m1_req_ready;

  assign req_wr    = (winner == REQ_M1) ? m1_req_wr    : m0_req_wr;
  assign req_addr  = (winner == REQ_M1) ? m1_req_addr  : m0_req_addr;
  assign req_wdata = (winner == REQ_M1) ? m1_req_wdata : m0_req_wdata;

  // A write responds straight after ISSUE with zero data; a read responds
  // when the countdown reaches zero, carrying the debug module's data.
  assign capture_rsp  = ((state == ST_ISSUE) && dmi_wr) ||
                        ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign rsp_data_nxt = (state == ST_WAIT) ? dmi_rdata : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = dmi_wr ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch the granted command, strobe the DMI, count the read
  // latency and deliver the response to the owner only. Priority flips on
  // every grant, contested or not, so continuous contention alternates.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prio         <= REQ_M0;
      owner        <= REQ_M0;
      wait_cnt     <= 4'd0;
      dmi_valid    <= 1'b0;
      dmi_wr       <= 1'b0;
      dmi_addr     <= '0;
      dmi_wdata    <= '0;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      m0_rsp_rdata <= '0;
      m1_rsp_rdata <= '0;
    end else begin
      dmi_valid    <= accept;
      m0_rsp_valid <= capture_rsp && (owner == REQ_M0);
      m1_rsp_valid <= capture_rsp && (owner == REQ_M1);

      if (accept) begin
        dmi_wr    <= req_wr;
        dmi_addr  <= req_addr;
        dmi_wdata <= req_wdata;
        owner     <= winner;
        prio      <= other_req(winner);
      end

      if (state == ST_ISSUE) begin
        wait_cnt <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (capture_rsp) begin
        if (owner == REQ_M0) begin
          m0_rsp_rdata <= rsp_data_nxt;
        end else begin
          m1_rsp_rdata <= rsp_data_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter
//   Directed bench for dmi_arbiter. Instance 0 runs with RD_LATENCY=1,
//   instance 1 with RD_LATENCY=3, each backed by a small debug-module model
//   whose read data appears exactly RD_LATENCY cycles after dmi_valid.
//   Expected grants, DMI accesses and responses are queued when stimulus is
//   issued; negedge monitors pop and compare them when the DUT shows them.
module tb_dmi_arbiter;
  import dmi_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index order: [dut][port]
  logic [1:0][1:0]         rv, rw, rr, rsv;
  logic [1:0][1:0][AW-1:0] ra;
  logic [1:0][1:0][DW-1:0] rwd, rsd;
  logic [1:0]              dv, dw;
  logic [1:0][AW-1:0]      da;
  logic [1:0][DW-1:0]      dwd, drd;

  dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m0_req_valid (rv[0][0]),
    .m0_req_ready (rr[0][0]),
    .m0_req_wr    (rw[0][0]),
    .m0_req_addr  (ra[0][0]),
    .m0_req_wdata (rwd[0][0]),
    .m0_rsp_valid (rsv[0][0]),
    .m0_rsp_rdata (rsd[0][0]),
    .m1_req_valid (rv[0][1]),
    .m1_req_ready (rr[0][1]),
    .m1_req_wr    (rw[0][1]),
    .m1_req_addr  (ra[0][1]),
    .m1_req_wdata (rwd[0][1]),
    .m1_rsp_valid (rsv[0][1]),
    .m1_rsp_rdata (rsd[0][1]),
    .dmi_valid    (dv[0]),
    .dmi_wr       (dw[0]),
    .dmi_addr     (da[0]),
    .dmi_wdata    (dwd[0]),
    .dmi_rdata    (drd[0])
  );

  dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
    .clk          (clk),
    .resetn       (resetn),
    .m0_req_valid (rv[1][0]),
    .m0_req_ready (rr[1][0]),
    .m0_req_wr    (rw[1][0]),
    .m0_req_addr  (ra[1][0]),
    .m0_req_wdata (rwd[1][0]),
    .m0_rsp_valid (rsv[1][0]),
    .m0_rsp_rdata (rsd[1][0]),
    .m1_req_valid (rv[1][1]),
    .m1_req_ready (rr[1][1]),
    .m1_req_wr    (rw[1][1]),
    .m1_req_addr  (ra[1][1]),
    .m1_req_wdata (rwd[1][1]),
    .m1_rsp_valid (rsv[1][1]),
    .m1_rsp_rdata (rsd[1][1]),
    .dmi_valid    (dv[1]),
    .dmi_wr       (dw[1]),
    .dmi_addr     (da[1]),
    .dmi_wdata    (dwd[1]),
    .dmi_rdata    (drd[1])
  );

  // Debug-module models: writes land on the strobe edge; read data is valid
  // only in the cycle exactly LAT cycles after the strobe, poison otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_dm
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem  [128];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
      if (dv[g] && dw[g]) mem[da[g]] <= dwd[g];
      pipe[0] <= (dv[g] && !dw[g]) ? mem[da[g]] : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign drd[g] = pipe[LAT-1];
  end

  typedef struct {
    int            dut;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } dmi_exp_t;

  typedef struct {
    int            dut;
    int            owner;
    logic [DW-1:0] rdata;
    int            cyc;
  } rsp_exp_t;

  typedef struct {
    int dut;
    int owner;
    int gap;
  } grant_exp_t;

  dmi_exp_t   expDmi[$];
  rsp_exp_t   expRsp[$];
  grant_exp_t expGrant[$];

  int nChecks = 0;
  int nPass   = 0;
  int lastH [2];

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  // Grant monitor: every handshake must be the next expected grant
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rv[d][p] && rr[d][p]) begin
          if (expGrant.size() == 0) begin
            checkOutput("grant_unexpected", 64'(rr[d][p]), 64'd0);
          end else begin
            grant_exp_t e;
            e = expGrant.pop_front();
            checkOutput("grant_dut", 64'(d), 64'(e.dut));
            checkOutput("grant_owner", 64'(p), 64'(e.owner));
            if (e.gap != 0)
              checkOutput("grant_gap", 64'(cyc - lastH[d]), 64'(e.gap));
          end
          lastH[d] = cyc;
        end
      end
    end
  end

  // DMI monitor: every strobe must match the next expected access
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (dv[d]) begin
        if (expDmi.size() == 0) begin
          checkOutput("dmi_unexpected", 64'(dv[d]), 64'd0);
        end else begin
          dmi_exp_t e;
          e = expDmi.pop_front();
          checkOutput("dmi_dut", 64'(d), 64'(e.dut));
          checkOutput("dmi_wr", 64'(dw[d]), 64'(e.wr));
          checkOutput("dmi_addr", 64'(da[d]), 64'(e.addr));
          checkOutput("dmi_wdata", 64'(dwd[d]), 64'(e.wdata));
          checkOutput("dmi_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Response monitor: every rsp pulse must match the next expected response
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rsv[d][p]) begin
          if (expRsp.size() == 0) begin
            checkOutput("rsp_unexpected", 64'(rsv[d][p]), 64'd0);
          end else begin
            rsp_exp_t e;
            e = expRsp.pop_front();
            checkOutput("rsp_dut", 64'(d), 64'(e.dut));
            checkOutput("rsp_owner", 64'(p), 64'(e.owner));
            checkOutput("rsp_rdata", 64'(rsd[d][p]), 64'(e.rdata));
            checkOutput("rsp_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  // Present one command, wait (bounded) for its handshake, queue the
  // expected strobe and response, then drop valid after the handshake edge.
  task automatic applyStimulus(input int d, input int p, input logic wr,
                               input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata,
                               input logic [DW-1:0] expRdata,
                               output int h);
    bit got = 1'b0;
    h = -1;
    rv[d][p]  = 1'b1;
    rw[d][p]  = wr;
    ra[d][p]  = addr;
    rwd[d][p] = wdata;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = rr[d][p];
    end
    if (!got) begin
      checkOutput("handshake_timeout", 64'(rr[d][p]), 64'd1);
      rv[d][p] = 1'b0;
      return;
    end
    h = cyc;
    expDmi.push_back('{d, wr, addr, wdata, h + 1});
    expRsp.push_back('{d, p, wr ? 32'h0 : expRdata,
                       h + 2 + (wr ? 0 : latOf(d))});
    @(posedge clk);
    #1;
    rv[d][p] = 1'b0;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 100 &&
         (expDmi.size() + expRsp.size() + expGrant.size()) != 0; k++)
      @(posedge clk);
    checkOutput("scoreboard_drain",
                64'(expDmi.size() + expRsp.size() + expGrant.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input int d);
    checkOutput("rst_dmi_valid", 64'(dv[d]), 64'd0);
    checkOutput("rst_dmi_wr", 64'(dw[d]), 64'd0);
    checkOutput("rst_dmi_addr", 64'(da[d]), 64'd0);
    checkOutput("rst_dmi_wdata", 64'(dwd[d]), 64'd0);
    checkOutput("rst_m0_rsp_valid", 64'(rsv[d][0]), 64'd0);
    checkOutput("rst_m1_rsp_valid", 64'(rsv[d][1]), 64'd0);
    checkOutput("rst_m0_rsp_rdata", 64'(rsd[d][0]), 64'd0);
    checkOutput("rst_m1_rsp_rdata", 64'(rsd[d][1]), 64'd0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int h, h0, h1, relCyc;
    rv = '0; rw = '0; ra = '0; rwd = '0;
    lastH[0] = 0;
    lastH[1] = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs(0);
    checkResetOutputs(1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] m0 write then m1 read of addr 3");
    expGrant.push_back('{0, 0, 0});
    applyStimulus(0, 0, 1'b1, 7'd3, 32'hDEAD_BEEF, 32'h0, h);
    waitDrain();
    expGrant.push_back('{0, 1, 0});
    applyStimulus(0, 1, 1'b0, 7'd3, 32'h0, 32'hDEAD_BEEF, h);
    waitDrain();

    $display("[TB] continuous contention from reset");
    resetn = 1'b0;
    expGrant.push_back('{0, 0, 0});
    expGrant.push_back('{0, 1, 3});
    expGrant.push_back('{0, 0, 3});
    expGrant.push_back('{0, 1, 3});
    fork
      begin
        applyStimulus(0, 0, 1'b1, 7'd5, 32'h11, 32'h0, h0);
        applyStimulus(0, 0, 1'b1, 7'd8, 32'hA0, 32'h0, h0);
      end
      begin
        applyStimulus(0, 1, 1'b1, 7'd5, 32'h22, 32'h0, h1);
        applyStimulus(0, 1, 1'b1, 7'd9, 32'hB1, 32'h0, h1);
      end
      begin
        @(posedge clk);
        #1;
        resetn = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] read back after contention");
    expGrant.push_back('{0, 0, 0});
    applyStimulus(0, 0, 1'b0, 7'd5, 32'h0, 32'h22, h);
    waitDrain();
    expGrant.push_back('{0, 1, 0});
    applyStimulus(0, 1, 1'b0, 7'd8, 32'h0, 32'hA0, h);
    waitDrain();

    $display("[TB] reset during WAIT of a read");
    expGrant.push_back('{0, 0, 0});
    rv[0][0] = 1'b1; rw[0][0] = 1'b0; ra[0][0] = 7'd9; rwd[0][0] = 32'h0;
    h = -1;
    for (int k = 0; k < 20 && h < 0; k++) begin
      @(negedge clk);
      if (rr[0][0]) h = cyc;
    end
    checkOutput("abort_handshake_seen", 64'(h >= 0), 64'd1);
    expDmi.push_back('{0, 1'b0, 7'd9, 32'h0, h + 1});
    @(posedge clk);
    #1;
    rv[0][0] = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    relCyc = cyc;
    expGrant.push_back('{0, 1, 0});
    fork
      applyStimulus(0, 1, 1'b1, 7'd10, 32'h55, 32'h0, h);
      begin
        @(negedge clk);
        checkResetOutputs(0);
      end
    join
    checkOutput("post_reset_accept_cycle", 64'(h), 64'(relCyc));
    waitDrain();

    $display("[TB] RD_LATENCY=3 instance");
    expGrant.push_back('{1, 0, 0});
    applyStimulus(1, 0, 1'b1, 7'd4, 32'hCAFE_F00D, 32'h0, h);
    waitDrain();
    expGrant.push_back('{1, 0, 0});
    applyStimulus(1, 0, 1'b0, 7'd4, 32'h0, 32'hCAFE_F00D, h);
    rv[1][1] = 1'b1; rw[1][1] = 1'b0; ra[1][1] = 7'd4; rwd[1][1] = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_ready_m1_H+%0d", k), 64'(rr[1][1]), 64'd0);
    end
    expGrant.push_back('{1, 1, 6});
    applyStimulus(1, 1, 1'b0, 7'd4, 32'h0, 32'hCAFE_F00D, h);
    waitDrain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
